// File: rtl/x25519_pkg.sv
// Shared types and constants for the X25519 scalar-multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package x25519_pkg;

    localparam int X25519_WIDTH = 256;

    // Default guard intervals: about 1M cycles, far beyond any legal core latency.
    localparam int DEF_TIMEOUT_CYCLES = 1048576;
    localparam int DEF_FLUSH_CYCLES   = 1048576;

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        IDLE   = 2'd1,
        LAUNCH = 2'd2,
        WAIT   = 2'd3
    } x25519_arb_state_t;

    // One buffered operation: u-coordinate and scalar travel together.
    typedef struct packed {
        logic [X25519_WIDTH-1:0] work_in;
        logic [X25519_WIDTH-1:0] e;
    } x25519_ops_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin first-set search over a pending vector, starting at rr_ptr and wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on found/index.
module rr_pick #(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         pending,
    input  logic [$clog2(NUM_PORTS)-1:0] rr_ptr,
    output logic                         found,
    output logic [$clog2(NUM_PORTS)-1:0] index
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] cand_sum;
    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit at/after rr_ptr wins.
    always_comb begin
        found    = 1'b0;
        index    = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr} + SUM_W'(k);
            if (cand_sum >= SUM_W'(NUM_PORTS)) begin
                cand_sum = cand_sum - SUM_W'(NUM_PORTS);
            end
            cand = cand_sum[IDX_W-1:0];
            if (pending[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/x25519_mult_arbiter.sv
// Round-robin arbiter sharing one X25519 scalar-mult core among NUM_PORTS requesters, with hang and stale-result guards.
// Latency: req_en -> mult_en 2 cycles when idle; core out_valid -> resp_valid 1 cycle.
// Backpressure: none; req_en to a busy port is dropped, responses are single-cycle strobes that cannot stall.
module x25519_mult_arbiter
    import x25519_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_PORTS-1:0]                     req_en,
    input  logic [NUM_PORTS-1:0][X25519_WIDTH-1:0]   req_work_in,
    input  logic [NUM_PORTS-1:0][X25519_WIDTH-1:0]   req_e,
    output logic [NUM_PORTS-1:0]                     req_busy,
    output logic                                     resp_valid,
    output logic [$clog2(NUM_PORTS)-1:0]             resp_port,
    output logic                                     resp_err,
    output logic [X25519_WIDTH-1:0]                  resp_data,
    output logic                                     mult_en,
    output logic [X25519_WIDTH-1:0]                  mult_work_in,
    output logic [X25519_WIDTH-1:0]                  mult_e,
    input  logic                                     mult_out_valid,
    input  logic [X25519_WIDTH-1:0]                  mult_work_out
);

    localparam int IDX_W   = $clog2(NUM_PORTS);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    x25519_arb_state_t       state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]    pending_q, pending_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                    mult_en_q, mult_en_d;
    x25519_ops_t             mult_ops_q, mult_ops_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic [IDX_W-1:0]        resp_port_q, resp_port_d;
    logic [X25519_WIDTH-1:0] resp_data_q, resp_data_d;
    x25519_ops_t             ops_q [NUM_PORTS];
    x25519_ops_t             ops_d [NUM_PORTS];

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        next_ptr;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .found   (pick_found),
        .index   (pick_idx)
    );

    assign next_ptr = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : owner_q + IDX_W'(1);

    // Capture operands into a port's buffer only when that port is not already busy.
    always_comb begin
        ops_d = ops_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_en[i] && !pending_q[i]) begin
                ops_d[i].work_in = req_work_in[i];
                ops_d[i].e       = req_e[i];
            end
        end
    end

    // Sequencer: flush guard, round-robin grant, one-cycle launch, bounded wait for the core.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        mult_en_d    = 1'b0;
        mult_ops_d   = mult_ops_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_port_d  = resp_port_q;
        resp_data_d  = resp_data_q;

        unique case (state_q)
            FLUSH: begin
                // Core strobes are ignored here so a result from an abandoned op cannot leak out.
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    mult_ops_d = ops_q[pick_idx];
                    mult_en_d  = 1'b1;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mult_out_valid) begin
                    resp_valid_d       = 1'b1;
                    resp_data_d        = mult_work_out;
                    resp_port_d        = owner_q;
                    pending_d[owner_q] = 1'b0;
                    rr_ptr_d           = next_ptr;
                    state_d            = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_valid_d       = 1'b1;
                    resp_err_d         = 1'b1;
                    resp_data_d        = '0;
                    resp_port_d        = owner_q;
                    pending_d[owner_q] = 1'b0;
                    rr_ptr_d           = next_ptr;
                    cnt_d              = '0;
                    state_d            = FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = FLUSH;
            end
        endcase

        // Busy is judged on the registered pending bit, so a port freed this cycle re-arms next cycle.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_en[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FLUSH;
            cnt_q        <= '0;
            pending_q    <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            mult_en_q    <= 1'b0;
            mult_ops_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_port_q  <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            mult_en_q    <= mult_en_d;
            mult_ops_q   <= mult_ops_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_port_q  <= resp_port_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Operand buffers are only read while their pending bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        ops_q <= ops_d;
    end

    assign req_busy     = pending_q;
    assign resp_valid   = resp_valid_q;
    assign resp_port    = resp_port_q;
    assign resp_err     = resp_err_q;
    assign resp_data    = resp_data_q;
    assign mult_en      = mult_en_q;
    assign mult_work_in = mult_ops_q.work_in;
    assign mult_e       = mult_ops_q.e;

endmodule

// File: tb/tb_x25519_mult_arbiter.sv
// Self-checking bench for x25519_mult_arbiter: XOR core model with fixed latency, request-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_x25519_mult_arbiter;
    import x25519_pkg::*;

    localparam int NP  = 4;
    localparam int TMO = 200;
    localparam int FLS = 16;
    localparam int LAT = 100;

    logic                      clk;
    logic                      rst_n;
    logic [NP-1:0]             req_en;
    logic [NP-1:0][255:0]      req_work_in;
    logic [NP-1:0][255:0]      req_e;
    logic [NP-1:0]             req_busy;
    logic                      resp_valid;
    logic [1:0]                resp_port;
    logic                      resp_err;
    logic [255:0]              resp_data;
    logic                      mult_en;
    logic [255:0]              mult_work_in;
    logic [255:0]              mult_e;
    logic                      mult_out_valid;
    logic [255:0]              mult_work_out;

    // Core model and forced-strobe injection
    logic                      core_ov;
    logic                      force_ov;
    logic [255:0]              core_dat;
    logic [255:0]              core_res;
    int                        core_cnt;
    bit                        m_hang;

    assign mult_out_valid = core_ov | force_ov;
    assign mult_work_out  = core_dat;

    x25519_mult_arbiter #(
        .NUM_PORTS      (NP),
        .TIMEOUT_CYCLES (TMO),
        .FLUSH_CYCLES   (FLS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_en         (req_en),
        .req_work_in    (req_work_in),
        .req_e          (req_e),
        .req_busy       (req_busy),
        .resp_valid     (resp_valid),
        .resp_port      (resp_port),
        .resp_err       (resp_err),
        .resp_data      (resp_data),
        .mult_en        (mult_en),
        .mult_work_in   (mult_work_in),
        .mult_e         (mult_e),
        .mult_out_valid (mult_out_valid),
        .mult_work_out  (mult_work_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model state (request level)
    logic [NP-1:0] m_busy, prev_busy;
    logic [255:0]  m_work [NP];
    logic [255:0]  m_e    [NP];
    int            m_rr, prev_rr, m_owner;
    bit            inflight;
    int            cyc, en_cyc, en_cnt, resp_cnt;
    int            last_resp_cyc, last_resp_port;
    logic          last_resp_err;
    logic [255:0]  last_resp_data;
    logic [NP-1:0] last_resp_busy;
    int            port_resp_cnt [NP];
    int            resp_q [$];

    // Drive requests for the next step
    logic [NP-1:0] drv_en;
    logic [255:0]  drv_work [NP];
    logic [255:0]  drv_e    [NP];
    bit            drv_force;
    bit            rereq_arm;

    // Core: returns work_in ^ e exactly LAT cycles after mult_en, unless hung.
    initial begin
        core_ov  = 1'b0;
        core_dat = '0;
        core_res = '0;
        core_cnt = 0;
        forever begin
            @(negedge clk);
            core_ov = 1'b0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_ov  = 1'b1;
                    core_dat = core_res;
                end
            end
            if (mult_en && !m_hang) begin
                core_cnt = LAT;
                core_res = mult_work_in ^ mult_e;
            end
        end
    end

    task automatic monitor();
        int own;
        if (mult_en) begin
            en_cnt++;
            check_eq("en_while_inflight", inflight, 0);
            own = -1;
            for (int k = 0; k < NP; k++) begin
                if (own < 0 && prev_busy[(prev_rr + k) % NP]) own = (prev_rr + k) % NP;
            end
            check_eq("grant_has_owner", own >= 0, 1);
            if (own >= 0) begin
                check_eq("grant_work", mult_work_in, m_work[own]);
                check_eq("grant_e", mult_e, m_e[own]);
                m_owner  = own;
                inflight = 1'b1;
                en_cyc   = cyc;
            end
        end
        if (resp_valid) begin
            resp_cnt++;
            last_resp_cyc  = cyc;
            last_resp_port = int'(resp_port);
            last_resp_err  = resp_err;
            last_resp_data = resp_data;
            last_resp_busy = req_busy;
            resp_q.push_back(int'(resp_port));
            port_resp_cnt[resp_port]++;
            check_eq("resp_expected", inflight, 1);
            if (inflight) begin
                check_eq("resp_port", resp_port, m_owner);
                check_eq("resp_err", resp_err, m_hang);
                check_eq("resp_data", resp_data, m_hang ? 256'h0 : (m_work[m_owner] ^ m_e[m_owner]));
                check_eq("resp_lat", cyc - en_cyc, m_hang ? TMO + 1 : LAT + 1);
                m_busy[m_owner] = 1'b0;
                m_rr     = (m_owner + 1) % NP;
                inflight = 1'b0;
            end
        end
        check_eq("busy", req_busy, m_busy);
        prev_busy = m_busy;
        prev_rr   = m_rr;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        if (rereq_arm && resp_valid && resp_port == 2'd2) begin
            drv_en[2]   = 1'b1;
            drv_work[2] = rand256();
            drv_e[2]    = rand256();
            rereq_arm   = 1'b0;
        end
        for (int i = 0; i < NP; i++) begin
            if (drv_en[i]) begin
                if (!m_busy[i]) begin
                    m_busy[i] = 1'b1;
                    m_work[i] = drv_work[i];
                    m_e[i]    = drv_e[i];
                end
                req_work_in[i] = drv_work[i];
                req_e[i]       = drv_e[i];
            end else begin
                req_work_in[i] = rand256();
                req_e[i]       = rand256();
            end
        end
        req_en    = drv_en;
        force_ov  = drv_force;
        drv_en    = '0;
        drv_force = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [255:0] w, input logic [255:0] e);
        drv_en[p]   = 1'b1;
        drv_work[p] = w;
        drv_e[p]    = e;
    endtask

    task automatic wait_en(input int budget, input string tag);
        int start = en_cnt;
        int n = 0;
        while (en_cnt == start && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, en_cnt != start, 1);
    endtask

    task automatic wait_resp(input int budget, input string tag);
        int start = resp_cnt;
        int n = 0;
        while (resp_cnt == start && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, resp_cnt != start, 1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((m_busy != '0 || inflight) && n < budget) begin
            step();
            n++;
        end
        check_eq(tag, {m_busy, inflight}, '0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_busy"},   req_busy, 0);
        check_eq({tag, "_rvalid"}, resp_valid, 0);
        check_eq({tag, "_rerr"},   resp_err, 0);
        check_eq({tag, "_rport"},  resp_port, 0);
        check_eq({tag, "_rdata"},  resp_data, 0);
        check_eq({tag, "_men"},    mult_en, 0);
        check_eq({tag, "_mwork"},  mult_work_in, 0);
        check_eq({tag, "_me"},     mult_e, 0);
    endtask

    // Called at a negedge right after a step: assert reset and clear the model.
    task automatic do_reset(input string tag);
        rst_n     = 1'b0;
        req_en    = '0;
        m_busy    = '0;
        prev_busy = '0;
        m_rr      = 0;
        prev_rr   = 0;
        inflight  = 1'b0;
        #1;
        check_reset_values(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, start, p1cnt;
        logic [255:0] aw, ae;

        rst_n = 1'b1; req_en = '0; req_work_in = '0; req_e = '0; force_ov = 1'b0;
        drv_en = '0; drv_force = 1'b0; rereq_arm = 1'b0; m_hang = 1'b0;
        m_busy = '0; prev_busy = '0; m_rr = 0; prev_rr = 0; m_owner = 0; inflight = 1'b0;
        cyc = 0; en_cyc = 0; en_cnt = 0; resp_cnt = 0;
        last_resp_cyc = 0; last_resp_port = 0; last_resp_err = 1'b0; last_resp_data = '0; last_resp_busy = '0;
        for (int i = 0; i < NP; i++) begin
            m_work[i] = '0; m_e[i] = '0; drv_work[i] = '0; drv_e[i] = '0; port_resp_cnt[i] = 0;
        end

        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("por");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (FLS + 4) step();

        // Fairness: all four ports at once, then ports 3 and 0
        resp_q.delete();
        for (int p = 0; p < NP; p++) set_req(p, 256'(p + 1) << 8, 256'(p + 17));
        step();
        wait_idle(1000, "fair1_drain");
        check_eq("fair1_count", resp_q.size(), 4);
        for (int k = 0; k < 4 && k < resp_q.size(); k++) check_eq("fair1_order", resp_q[k], k);
        resp_q.delete();
        set_req(3, rand256(), rand256());
        set_req(0, rand256(), rand256());
        step();
        wait_idle(500, "fair2_drain");
        check_eq("fair2_count", resp_q.size(), 2);
        if (resp_q.size() == 2) begin
            check_eq("fair2_first", resp_q[0], 0);
            check_eq("fair2_second", resp_q[1], 3);
        end

        // Single request: 9 ^ 5 = 0xC
        repeat (3) step();
        set_req(0, 256'd9, 256'd5);
        step();
        t0 = cyc;
        step();
        check_eq("single_busy_t1", req_busy[0], 1);
        wait_en(10, "single_en_seen");
        check_eq("single_en_lat", en_cyc - t0, 2);
        wait_resp(200, "single_resp_seen");
        check_eq("single_resp_lat", last_resp_cyc - en_cyc, LAT + 1);
        check_eq("single_resp_port", last_resp_port, 0);
        check_eq("single_resp_data", last_resp_data, 256'hC);
        check_eq("single_busy_low", last_resp_busy[0], 0);

        // Dropped request while busy
        repeat (2) step();
        aw = rand256(); ae = rand256();
        p1cnt = port_resp_cnt[1];
        set_req(1, aw, ae);
        step();
        repeat (5) step();
        set_req(1, rand256(), rand256());
        step();
        wait_resp(200, "drop_resp_seen");
        check_eq("drop_resp_data", last_resp_data, aw ^ ae);
        repeat (120) step();
        check_eq("drop_resp_count", port_resp_cnt[1] - p1cnt, 1);

        // Hung core: timeout, then a forced strobe during flush must be ignored
        m_hang = 1'b1;
        set_req(2, rand256(), rand256());
        step();
        wait_en(10, "hang_en_seen");
        t0 = en_cyc;
        wait_resp(TMO + 20, "hang_resp_seen");
        check_eq("hang_lat", last_resp_cyc - t0, TMO + 1);
        check_eq("hang_err", last_resp_err, 1);
        check_eq("hang_data", last_resp_data, 0);
        start = resp_cnt;
        repeat (4) step();
        drv_force = 1'b1;
        step();
        repeat (FLS + 4) step();
        check_eq("flush_force_ignored", resp_cnt - start, 0);
        m_hang = 1'b0;

        // Reset mid-operation
        set_req(3, rand256(), rand256());
        step();
        wait_en(10, "rst_en_seen");
        repeat (50) step();
        start = resp_cnt;
        do_reset("midrst");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (90) step();
        check_eq("midrst_no_resp", resp_cnt - start, 0);
        set_req(1, rand256(), rand256());
        step();
        wait_resp(200, "midrst_new_resp_seen");
        check_eq("midrst_new_port", last_resp_port, 1);
        check_eq("midrst_new_err", last_resp_err, 0);

        // Re-request in the same cycle as own response
        repeat (2) step();
        rereq_arm = 1'b1;
        set_req(2, rand256(), rand256());
        step();
        wait_resp(200, "rereq_first_seen");
        check_eq("rereq_fired", rereq_arm, 0);
        step();
        check_eq("rereq_busy_next", req_busy[2], 1);
        wait_resp(200, "rereq_second_seen");
        check_eq("rereq_second_port", last_resp_port, 2);
        rereq_arm = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 39) == 0) set_req(p, rand256(), rand256());
            end
            step();
        end
        wait_idle(4000, "random_drain");
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
